// File: rtl/mem_access_unit.sv
// Data-side memory access unit: turns M-stage loads/stores into single
// request/response bus transactions, aligns store data and formats load data.
module mem_access_unit #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memtoregM,
  input  logic [3:0]    memwriteM,
  input  logic [2:0]    lshbM,
  input  logic [31:0]   aluoutM,
  input  logic [31:0]   writedataM,
  input  logic          advanceM,
  output logic          stallM,
  output logic [31:0]   readdataM,
  output logic          adelM,
  output logic          adesM,
  output logic          bus_err,
  output logic          d_req,
  output logic          d_wr,
  output logic [3:0]    d_wstrb,
  output logic [AW-1:0] d_addr,
  output logic [31:0]   d_wdata,
  input  logic          d_addr_ok,
  input  logic          d_data_ok,
  input  logic [31:0]   d_rdata,
  output logic [1:0]    dbg_state
);

  // Bus handshake: a request is held (d_req=1, address/strobes/data stable)
  // until d_addr_ok is seen in the same cycle; exactly one d_data_ok then
  // completes it. Only one transaction is ever outstanding.
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  localparam logic [7:0] TO8 = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;

  logic        is_store, is_load, req_v, is_half, is_word, misaligned, go;
  logic        req_c, stall_c;
  logic [31:0] rsh, load_fmt;
  logic [15:0] half_v;
  logic [7:0]  byte_v;

  always_comb begin
    is_store = |memwriteM;
    is_load  = memtoregM & ~is_store;
    req_v    = memtoregM | is_store;
    is_half  = 1'b0;
    is_word  = 1'b0;
    if (is_store) begin
      case (memwriteM)
        4'b0001: ;
        4'b0011: is_half = 1'b1;
        default: is_word = 1'b1;
      endcase
    end else begin
      case (lshbM)
        3'b001, 3'b010: is_half = 1'b1;
        3'b011, 3'b100: ;
        default:        is_word = 1'b1;
      endcase
    end
    misaligned = (is_half & aluoutM[0]) | (is_word & (|aluoutM[1:0]));
    adelM      = is_load & misaligned;
    adesM      = is_store & misaligned;
    go         = req_v & ~misaligned;

    d_wr    = is_store;
    d_addr  = {aluoutM[AW-1:2], 2'b00};
    d_wstrb = is_store ? (memwriteM << aluoutM[1:0]) : 4'b0000;
    if (is_half)      d_wdata = {2{writedataM[15:0]}};
    else if (is_word) d_wdata = writedataM;
    else              d_wdata = {4{writedataM[7:0]}};
  end

  always_comb begin
    rsh    = d_rdata >> {aluoutM[1:0], 3'b000};
    byte_v = rsh[7:0];
    half_v = aluoutM[1] ? d_rdata[31:16] : d_rdata[15:0];
    case (lshbM)
      3'b001:  load_fmt = {{16{half_v[15]}}, half_v};
      3'b010:  load_fmt = {16'h0000, half_v};
      3'b011:  load_fmt = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_fmt = {24'h000000, byte_v};
      default: load_fmt = d_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    readdataM = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          req_c   = 1'b1;
          stall_c = 1'b1;
          state_d = d_addr_ok ? S_DATA : S_ADDR;
        end
      end
      S_ADDR: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (d_addr_ok) state_d = S_DATA;
      end
      S_DATA: begin
        stall_c = ~d_data_ok;
        if (d_data_ok) begin
          readdataM = load_fmt;
          rdata_d   = load_fmt;
          cnt_d     = 8'd0;
          state_d   = advanceM ? S_IDLE : S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TO8) begin
            bus_err_d = 1'b1;
            rdata_d   = 32'h0;
            cnt_d     = 8'd0;
            state_d   = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Completed access parks here so a held pipeline never reissues it.
        if (advanceM) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request and stall are forced low while reset is held, not just after it.
  assign d_req     = req_c & rst;
  assign stallM    = stall_c & rst;
  assign bus_err   = bus_err_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rdata_q   <= 32'h0;
      cnt_q     <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-side consumer of the M-stage memory controls produced by the pipeline controller: memwriteM byte-width mask, memtoregM and lshbM.
- Converts each load or store in M into one request/response transaction on an SRAM-like data bus, and stalls the pipeline until the response arrives.
- Aligns store data and byte enables.
- Extracts, shifts and sign- or zero-extends load data before it enters the M/W register.
- Flags misaligned accesses instead of issuing them.

Parameters:
- AW, 32, data bus address width.
- TIMEOUT, 255, number of DATA-state cycles without data_ok before bus_err is raised.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- memtoregM  in  1  load in M.
- memwriteM  in  4  store width mask: 0001 byte, 0011 half, 1111 word, 0000 no store.
- lshbM  in  3  load type: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; other codes are treated as LW.
- aluoutM  in  32  effective address.
- writedataM  in  32  store data, unaligned (low bits).
- advanceM  in  1  pipeline moves M to W at this edge.
- stallM  out  1  hold the pipeline.
- readdataM  out  32  aligned and extended load result.
- adelM  out  1  misaligned load.
- adesM  out  1  misaligned store.
- bus_err  out  1  sticky timeout flag.
- d_req  out  1  bus request.
- d_wr  out  1  1 = write.
- d_wstrb  out  4  byte strobes.
- d_addr  out  AW  word-aligned address.
- d_wdata  out  32  write data.
- d_addr_ok  in  1  request accepted.
- d_data_ok  in  1  response valid (write ack or read data).
- d_rdata  in  32  read data.

Behaviour:
- **Request validity:** req_v = memtoregM | (|memwriteM). A simultaneous load and store is treated as a store.
- **Alignment:**
  - Half access is misaligned if addr[0]=1.
  - Word access is misaligned if addr[1:0]!=0.
  - adelM/adesM are combinational, valid when req_v.
  - A misaligned access issues no bus request, does not stall, and leaves the FSM in IDLE.
- **Store formatting:**
  - d_wstrb = memwriteM << addr[1:0].
  - d_wdata = byte replicated x4 for SB, half replicated x2 for SH, word unchanged for SW.
  - d_addr = {aluoutM[AW-1:2],2'b00}.
  - d_wstrb = 0000 for loads.
- **FSM states:** IDLE, ADDR, DATA, DONE.
- **IDLE:**
  - If req_v and aligned, d_req=1 combinationally.
  - If d_addr_ok, go to DATA; else go to ADDR.
  - stallM=1 in both cases.
- **ADDR:** d_req=1 with stable address/strobes/data; stallM=1; go to DATA on d_addr_ok.
- **DATA:**
  - d_req=0; stallM = ~d_data_ok.
  - On d_data_ok, latch the formatted load result into rdata_q and go to DONE.
  - The data_ok cycle itself has stallM=0. If advanceM is also 1, go to IDLE instead of DONE.
- **DONE:**
  - stallM=0.
  - Hold rdata_q until advanceM, then go to IDLE.
  - Prevents reissuing an access while the pipeline is held by another stall source.
- **readdataM:**
  - Equals the formatted d_rdata in the data_ok cycle and rdata_q in DONE.
  - Formatting: sign- or zero-extended byte/half selected by addr[1:0], or the full word.
  - Outside those cycles readdataM = rdata_q.
- **Latency:** minimum 2 cycles from req_v to stallM falling (addr_ok in cycle 0, data_ok in cycle 1); stallM is high for exactly 1 cycle in that case.
- **Timeout:**
  - An 8-bit counter increments each DATA cycle without data_ok.
  - At TIMEOUT, set bus_err (sticky until reset), force DONE with rdata_q=0, and drop stallM.
- **Reset (async, rst=0):**
  - state=IDLE, rdata_q=0, counter=0, bus_err=0.
  - Outputs: d_req=0, stallM=0.
  - Reset mid-transaction abandons the transaction; a late d_data_ok after reset is ignored in IDLE.
- **Ordering:** one outstanding transaction only; d_addr_ok is ignored outside IDLE/ADDR, d_data_ok outside DATA.

Test Plan:
- LW addr 0x100, d_rdata 0x8899AABB, addr_ok in cycle 0, data_ok in cycle 1 -> stallM high 1 cycle; readdataM=0x8899AABB; d_wstrb=0000.
- LB addr 0x103 with d_rdata 0x80112233 -> readdataM=0xFFFFFF80; LBU -> 0x00000080; LH addr 0x102 -> 0xFFFF8011; LHU -> 0x00008011.
- SB addr 0x101, writedataM 0x12345678 -> d_wstrb=0010, d_wdata=0x78787878, d_wr=1; SH addr 0x102 -> d_wstrb=1100, d_wdata=0x56785678.
- LW addr 0x102 -> adelM=1, d_req=0, stallM=0; SH addr 0x101 -> adesM=1, no request.
- addr_ok delayed 3 cycles, data_ok 2 cycles later, advanceM=0 for 2 extra cycles -> exactly one request, d_addr stable while waiting, DONE holds readdataM until advanceM, no reissue.
- data_ok never arrives -> after 255 DATA cycles bus_err=1, stallM=0, readdataM=0; rst pulsed low mid-DATA -> IDLE and stallM=0 immediately, later data_ok ignored.
